// File: rtl/mips_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes,
// opcode/funct fields, ALUOp classes and ALUControl operations.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instruction[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operations
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp classes from the main FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mips_control_fsm_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp class and the funct field to an ALU operation.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl
);

  // Only ALUOp 10 looks at funct; unknown funct codes fall back to add.
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FUNCT_ADD: ALUControl = ALU_ADD;
          FUNCT_SUB: ALUControl = ALU_SUB;
          FUNCT_AND: ALUControl = ALU_AND;
          FUNCT_OR:  ALUControl = ALU_OR;
          FUNCT_SLT: ALUControl = ALU_SLT;
          default:   ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS controller: state register, next-state logic and Moore
// output decode for every datapath enable and ALU select.
module mips_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] aluop;
  logic       pcwrite_raw;
  logic       irwrite_raw;
  logic       branch;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; Op is sampled combinationally in DECODE and MEMADR.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        if (Op == OP_LW)      state_d = MEMREAD;
        else if (Op == OP_SW) state_d = MEMWRITE;
        else                  state_d = FETCH;
      end
      MEMREAD:  state_d = MEMWB;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  // Moore output decode; anything not named for a state stays 0.
  always_comb begin
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    aluop       = ALUOP_ADD;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    irwrite_raw = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    PCSrc       = 2'b00;
    pcwrite_raw = 1'b0;
    branch      = 1'b0;
    case (state_q)
      FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite_raw = 1'b1;
        ALUSrcB     = 2'b01;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMREAD: begin
        IorD = 1'b1;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
        PCSrc   = 2'b01;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
      end
      JUMP: begin
        pcwrite_raw = 1'b1;
        PCSrc       = 2'b10;
      end
      default: ;
    endcase
  end

  // While reset is held the FSM sits in FETCH; its PC/IR enables are masked
  // so nothing is written until the first edge after release.
  assign IRWrite = irwrite_raw & ~reset;
  assign PCEn    = (pcwrite_raw & ~reset) | (branch & Zero);
  assign state   = state_q;

  alu_decoder u_alu_decoder (
    .ALUOp      (aluop),
    .Funct      (Funct),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed testbench for mips_control_fsm: walks each instruction class
// through its state sequence and checks state plus all control outputs.
module tb_mips_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  mips_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .PCSrc      (PCSrc),
    .PCEn       (PCEn),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {ALUSrcA, ALUSrcB, ALUControl, IorD, MemWrite, IRWrite,
  //               RegWrite, RegDst, MemtoReg, PCSrc, PCEn}
  logic [14:0] ctrl;
  assign ctrl = {ALUSrcA, ALUSrcB, ALUControl, IorD, MemWrite, IRWrite,
                 RegWrite, RegDst, MemtoReg, PCSrc, PCEn};

  localparam logic [14:0] W_RST   = 15'b0_01_010_0_0_0_0_0_0_00_0;
  localparam logic [14:0] W_FETCH = 15'b0_01_010_0_0_1_0_0_0_00_1;
  localparam logic [14:0] W_DEC   = 15'b0_11_010_0_0_0_0_0_0_00_0;
  localparam logic [14:0] W_MADR  = 15'b1_10_010_0_0_0_0_0_0_00_0;
  localparam logic [14:0] W_MRD   = 15'b0_00_010_1_0_0_0_0_0_00_0;
  localparam logic [14:0] W_MWB   = 15'b0_00_010_0_0_0_1_0_1_00_0;
  localparam logic [14:0] W_MWR   = 15'b0_00_010_1_1_0_0_0_0_00_0;
  localparam logic [14:0] W_EXSLT = 15'b1_00_111_0_0_0_0_0_0_00_0;
  localparam logic [14:0] W_ALUWB = 15'b0_00_010_0_0_0_1_1_0_00_0;
  localparam logic [14:0] W_BRZ1  = 15'b1_00_110_0_0_0_0_0_0_01_1;
  localparam logic [14:0] W_BRZ0  = 15'b1_00_110_0_0_0_0_0_0_01_0;
  localparam logic [14:0] W_ADDEX = 15'b1_10_010_0_0_0_0_0_0_00_0;
  localparam logic [14:0] W_ADDWB = 15'b0_00_010_0_0_0_1_0_0_00_0;
  localparam logic [14:0] W_JUMP  = 15'b0_00_010_0_0_0_0_0_0_10_1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Op    = 6'b100011;
    Funct = 6'b100010;
    Zero  = 1'b1;
    #2;
    repeat (3) tick();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", state);
    end
    checks++;
    if (ctrl !== W_RST) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b", ctrl, W_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (ctrl !== W_FETCH) begin
      errors++;
      $display("FAIL reset_release_ctrl: got %b expected %b", ctrl, W_FETCH);
    end
  endtask

  // Entered mid-cycle in FETCH right after reset release, Op already lw.
  task automatic test_lw();
    logic [3:0]  es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [14:0] ec [6] = '{W_FETCH, W_DEC, W_MADR, W_MRD, W_MWB, W_FETCH};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL lw_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL lw_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
    end
  endtask

  task automatic test_rtype_slt();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [14:0] ec [5] = '{W_FETCH, W_DEC, W_EXSLT, W_ALUWB, W_FETCH};
    Op    = 6'b000000;
    Funct = 6'b101010;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL rtype_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL rtype_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
    end
  endtask

  // Each funct code through EXECUTE, including an unlisted code and 000000.
  task automatic test_rtype_functs();
    logic [5:0] fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b000000, 6'b111111};
    logic [2:0] ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b010, 3'b010};
    Op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      Funct = fn[k];
      tick();
      tick();
      checks++;
      if (state !== 4'd6 || ctrl !== {1'b1, 2'b00, ac[k], 9'b0}) begin
        errors++;
        $display("FAIL rtype_funct %b: state %0d ctrl %b expected state 6 ctrl %b",
                 fn[k], state, ctrl, {1'b1, 2'b00, ac[k], 9'b0});
      end
      tick();
      tick();
      checks++;
      if (state !== 4'd0) begin
        errors++;
        $display("FAIL rtype_funct_return %b: got %0d expected 0", fn[k], state);
      end
    end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [14:0] ec [4];
    ec[0] = W_FETCH;
    ec[1] = W_DEC;
    ec[2] = z ? W_BRZ1 : W_BRZ0;
    ec[3] = W_FETCH;
    Op    = 6'b000100;
    Funct = 6'b101010;
    Zero  = z;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL beq_z%0d_state step %0d: got %0d expected %0d", z, i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL beq_z%0d_ctrl step %0d: got %b expected %b", z, i, ctrl, ec[i]);
      end
    end
    Zero = 1'b1;
  endtask

  task automatic test_sw();
    logic [3:0]  es [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic [14:0] ec [5] = '{W_FETCH, W_DEC, W_MADR, W_MWR, W_FETCH};
    Op    = 6'b101011;
    Funct = 6'b100101;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL sw_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL sw_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
    end
  endtask

  task automatic test_j();
    logic [3:0]  es [4] = '{4'd0, 4'd1, 4'd11, 4'd0};
    logic [14:0] ec [4] = '{W_FETCH, W_DEC, W_JUMP, W_FETCH};
    Op = 6'b000010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL j_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL j_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
    end
  endtask

  // addi immediately followed by an unknown opcode, no idle cycles between.
  task automatic test_back_to_back();
    logic [3:0]  es [7] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd1, 4'd0};
    logic [14:0] ec [7] = '{W_FETCH, W_DEC, W_ADDEX, W_ADDWB, W_FETCH, W_DEC, W_FETCH};
    Op    = 6'b001000;
    Funct = 6'b100100;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      if (i == 4) Op = 6'b111111;
      checks++;
      if (state !== es[i]) begin
        errors++;
        $display("FAIL b2b_state step %0d: got %0d expected %0d", i, state, es[i]);
      end
      checks++;
      if (ctrl !== ec[i]) begin
        errors++;
        $display("FAIL b2b_ctrl step %0d: got %b expected %b", i, ctrl, ec[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    Op    = 6'b100011;
    Funct = 6'b000000;
    repeat (3) tick();
    checks++;
    if (state !== 4'd3) begin
      errors++;
      $display("FAIL mid_reach_memread: got %0d expected 3", state);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL mid_async_state: got %0d expected 0", state);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (state !== 4'd0 || ctrl !== W_RST) begin
        errors++;
        $display("FAIL mid_held %0d: state %0d ctrl %b expected state 0 ctrl %b",
                 i, state, ctrl, W_RST);
      end
    end
    Op = 6'b000010;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || ctrl !== W_FETCH) begin
      errors++;
      $display("FAIL mid_release: state %0d ctrl %b expected state 0 ctrl %b",
               state, ctrl, W_FETCH);
    end
    tick();
    tick();
    checks++;
    if (state !== 4'd11 || ctrl !== W_JUMP) begin
      errors++;
      $display("FAIL mid_after_jump: state %0d ctrl %b expected state 11 ctrl %b",
               state, ctrl, W_JUMP);
    end
    tick();
    checks++;
    if (state !== 4'd0) begin
      errors++;
      $display("FAIL mid_return: got %0d expected 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_slt();
    test_rtype_functs();
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw();
    test_j();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
